cpu_irq_ctrl: RTL and testbench
===============================

Name: cpu_irq_ctrl

Overview:
Interrupt controller that sits at the requesting end of the cpu_pc interrupt handshake. It collects N_SRC peripheral interrupt lines, latches rising edges as pending and applies a software enable mask. It picks the highest-priority pending source, drives `interrupt` to cpu_pc and holds it until `interrupt_grant`. It then reports the serviced source id until the ISR signals end-of-interrupt.

Parameters:
N_SRC, 8, number of interrupt source lines (2..32)
ID_W, 3, width of source id; must equal clog2(N_SRC)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
irq_src  input  N_SRC  raw peripheral interrupt lines, synchronous to clk
irq_en_we  input  1  write strobe for enable mask
irq_en_wdata  input  N_SRC  new enable mask value
eoi  input  1  end-of-interrupt pulse from ISR return
interrupt_grant  input  1  grant pulse from cpu_pc
interrupt  output  1  interrupt request to cpu_pc
irq_id  output  ID_W  id of requested or in-service source
irq_active  output  1  a granted interrupt is in service
irq_pending  output  N_SRC  pending bit vector (read-back)
irq_en  output  N_SRC  current enable mask (read-back)

Behaviour:
- Reset, synchronous and active-high; the following hold on the cycle after reset is sampled high: interrupt=0, irq_id=0, irq_active=0, irq_pending=0, irq_en=0, src_q=0, state=IDLE. Reset mid-handshake aborts the handshake with no residue.
- Edge detect: src_q registers irq_src. pending[i] sets on (irq_src[i] & ~src_q[i]), regardless of enable. Pending becomes visible 1 cycle after the edge.
- irq_en_we: irq_en <= irq_en_wdata next cycle.
- Priority: lowest index among (pending & irq_en) wins. This is combinational inside the controller.
- FSM states IDLE, REQ, SERVICE.
- IDLE: if (pending & irq_en) != 0, latch the winner into irq_id, set interrupt=1 and go to REQ. interrupt rises 1 cycle after the pending bit is visible.
- REQ: interrupt held at 1 and irq_id frozen, even if the mask or pending bits change. On interrupt_grant: interrupt=0, irq_active=1, pending[irq_id] cleared, go to SERVICE.
- SERVICE: no new request is raised; this means no nesting. On eoi: irq_active=0, go to IDLE. A new request may be raised the cycle after returning to IDLE.
- Simultaneous new edge on source irq_id in the grant cycle: set wins, and the pending bit stays 1.
- interrupt_grant outside REQ is ignored. eoi outside SERVICE is ignored. eoi and grant arriving in the same cycle in REQ: grant is processed and eoi is ignored.
- A source disabled while pending keeps its pending bit. It is requested later if re-enabled.

Optional Feature:
Macro CPU_IRQ_LEVEL_EN.
- Defined: sources are level-sensitive. pending = irq_src registered each cycle. The grant does not clear pending; the peripheral must drop its line before eoi, otherwise the source re-requests after IDLE.
- Undefined: edge-latched behaviour as specified above.

Decomposition:
- Package cpu_irq_pkg holds the state enum (IDLE/REQ/SERVICE), the N_SRC/ID_W defaults and the IRQ_ID_NONE constant.
- One sub-module, cpu_irq_prio_enc: a parameterised combinational lowest-index priority encoder with outputs any_valid and id.

Test Plan:
1. Reset held 100 ns, then irq_en=8'hFF, irq_src[3] 0->1 -> pending=8'h08 next cycle, interrupt=1 and irq_id=3 one cycle later; interrupt held with no grant for 20 cycles.
2. From state REQ, pulse interrupt_grant for 1 cycle -> interrupt=0, irq_active=1, pending=8'h00 next cycle. Then pulse eoi -> irq_active=0, state IDLE.
3. Edges on sources 5 and 2 in the same cycle, enable=8'hFF -> irq_id=2 served first. After eoi, irq_id=5 is requested the cycle after IDLE.
4. irq_en=8'h00 and edge on source 1 -> pending=8'h02 with interrupt=0. Write irq_en=8'h02 -> interrupt=1 and irq_id=1 two cycles after the write.
5. Grant pulse in IDLE, eoi in REQ, and an edge on source irq_id in the grant cycle -> grant and eoi ignored, pending bit stays 1 after the grant, and the source is re-requested after eoi.
6. Reset asserted while in SERVICE with pending=8'h10 -> all outputs 0 next cycle; no request after reset deasserts until a new edge occurs.

Source files
------------

// File: rtl/cpu_irq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_irq_pkg                                                |
// | Description : Shared types and defaults for the cpu_irq_ctrl interrupt   |
// |               controller: handshake state enum, default source count     |
// |               and id width, and the reset value of the reported id.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_irq_pkg;

   // Default number of interrupt source lines and matching id width
   localparam int N_SRC_DEF = 8;
   localparam int ID_W_DEF  = 3;

   // Id reported when nothing has been requested since reset
   localparam int unsigned IRQ_ID_NONE = 0;

   // Handshake with cpu_pc: wait for work, hold request, wait for ISR return
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

endpackage : cpu_irq_pkg
`default_nettype wire

// File: rtl/cpu_irq_prio_enc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_irq_prio_enc                                           |
// | Description : Combinational lowest-index priority encoder.               |
// |   req       [N-1:0]    candidate request vector                          |
// |   any_valid            at least one request bit is set                   |
// |   id        [ID_W-1:0] index of the lowest set bit (0 when none)         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_irq_prio_enc #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    req,
   output logic            any_valid,
   output logic [ID_W-1:0] id
);

   // Scan from the top down so the lowest set index is the last assignment
   always_comb begin
      any_valid = |req;
      id        = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = ID_W'(i);
         end
      end
   end

endmodule : cpu_irq_prio_enc
`default_nettype wire

// File: rtl/cpu_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_irq_ctrl                                               |
// | Description : Interrupt controller on the requesting side of the cpu_pc  |
// |               interrupt handshake. Latches rising edges of the source    |
// |               lines as pending, masks them with a software enable,       |
// |               requests the lowest-index enabled pending source and       |
// |               reports it as in service until end-of-interrupt.           |
// |   clk              system clock, rising edge                             |
// |   reset            synchronous, active-high reset                        |
// |   irq_src          raw peripheral interrupt lines                        |
// |   irq_en_we/wdata  enable mask write strobe and value                    |
// |   eoi              end-of-interrupt pulse from ISR return                |
// |   interrupt_grant  grant pulse from cpu_pc                               |
// |   interrupt        request to cpu_pc                                     |
// |   irq_id           id of requested or in-service source                  |
// |   irq_active       a granted interrupt is in service                     |
// |   irq_pending      pending bit vector read-back                          |
// |   irq_en           enable mask read-back                                 |
// | Build option: CPU_IRQ_LEVEL_EN - when defined, sources are level-        |
// |   sensitive (pending mirrors the registered lines, grant does not        |
// |   clear it); otherwise rising edges are latched until granted.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_irq_ctrl
   import cpu_irq_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             irq_en_we,
   input  logic [N_SRC-1:0] irq_en_wdata,
   input  logic             eoi,
   input  logic             interrupt_grant,
   output logic             interrupt,
   output logic [ID_W-1:0]  irq_id,
   output logic             irq_active,
   output logic [N_SRC-1:0] irq_pending,
   output logic [N_SRC-1:0] irq_en
);

   // Registered state
   irq_state_e       state_q,      state_d;
   logic [N_SRC-1:0] src_q,        src_d;
   logic [N_SRC-1:0] pending_q,    pending_d;
   logic [N_SRC-1:0] en_q,         en_d;
   logic             interrupt_q,  interrupt_d;
   logic [ID_W-1:0]  irq_id_q,     irq_id_d;
   logic             irq_active_q, irq_active_d;

   // Combinational helpers
   logic [N_SRC-1:0] req_vec;
   logic [N_SRC-1:0] grant_clr;
   logic             win_valid;
   logic [ID_W-1:0]  win_id;
`ifndef CPU_IRQ_LEVEL_EN
   logic [N_SRC-1:0] src_rise;
`endif

   assign req_vec = pending_q & en_q;

   cpu_irq_prio_enc #(
      .N    (N_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req       (req_vec),
      .any_valid (win_valid),
      .id        (win_id)
   );

   always_comb begin
      state_d      = state_q;
      interrupt_d  = interrupt_q;
      irq_id_d     = irq_id_q;
      irq_active_d = irq_active_q;
      grant_clr    = '0;
      src_d        = irq_src;
      en_d         = irq_en_we ? irq_en_wdata : en_q;

      case (state_q)
         IDLE: begin
            // The winner is captured here and frozen for the whole request,
            // so later mask or pending changes cannot retarget it.
            if (win_valid) begin
               irq_id_d    = win_id;
               interrupt_d = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            // eoi arriving alongside the grant is deliberately not looked at
            if (interrupt_grant) begin
               interrupt_d  = 1'b0;
               irq_active_d = 1'b1;
               grant_clr    = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q;
               state_d      = SERVICE;
            end
         end
         SERVICE: begin
            if (eoi) begin
               irq_active_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            interrupt_d  = 1'b0;
            irq_active_d = 1'b0;
            state_d      = IDLE;
         end
      endcase

`ifdef CPU_IRQ_LEVEL_EN
      // Level mode: pending simply follows the lines one cycle late
      pending_d = irq_src;
`else
      // The set term is OR-ed after the clear so a fresh edge on the source
      // being granted in the same cycle is not lost.
      src_rise  = irq_src & ~src_q;
      pending_d = (pending_q & ~grant_clr) | src_rise;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         src_q        <= '0;
         pending_q    <= '0;
         en_q         <= '0;
         interrupt_q  <= 1'b0;
         irq_id_q     <= ID_W'(IRQ_ID_NONE);
         irq_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         pending_q    <= pending_d;
         en_q         <= en_d;
         interrupt_q  <= interrupt_d;
         irq_id_q     <= irq_id_d;
         irq_active_q <= irq_active_d;
      end
   end

   assign interrupt   = interrupt_q;
   assign irq_id      = irq_id_q;
   assign irq_active  = irq_active_q;
   assign irq_pending = pending_q;
   assign irq_en      = en_q;

endmodule : cpu_irq_ctrl
`default_nettype wire

// File: tb/tb_cpu_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_irq_ctrl                                            |
// | Description : Self-checking bench for cpu_irq_ctrl. A behavioural model  |
// |               tracks pending/enable/handshake phase and is compared with |
// |               the DUT every cycle; directed steps add literal checks.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_irq_ctrl;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] irq_src;
   logic         irq_en_we;
   logic [N-1:0] irq_en_wdata;
   logic         eoi;
   logic         interrupt_grant;
   logic         interrupt;
   logic [W-1:0] irq_id;
   logic         irq_active;
   logic [N-1:0] irq_pending;
   logic [N-1:0] irq_en;

   int n_total = 0;
   int n_pass  = 0;

   cpu_irq_ctrl #(.N_SRC(N), .ID_W(W)) dut (
      .clk             (clk),
      .reset           (reset),
      .irq_src         (irq_src),
      .irq_en_we       (irq_en_we),
      .irq_en_wdata    (irq_en_wdata),
      .eoi             (eoi),
      .interrupt_grant (interrupt_grant),
      .interrupt       (interrupt),
      .irq_id          (irq_id),
      .irq_active      (irq_active),
      .irq_pending     (irq_pending),
      .irq_en          (irq_en)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for work, 1 request outstanding, 2 being serviced
   int       m_phase;
   bit [N-1:0] m_pend, m_en, m_prev;
   bit       m_int, m_act;
   int       m_id;
   bit       m_valid = 0;

   always @(posedge clk) begin
      bit [N-1:0] rise, npend, cand;
      if (reset) begin
         m_phase = 0; m_pend = '0; m_en = '0; m_prev = '0;
         m_int = 0; m_act = 0; m_id = 0; m_valid = 1;
      end else begin
         rise  = irq_src & ~m_prev;
`ifdef CPU_IRQ_LEVEL_EN
         npend = irq_src;
`else
         npend = m_pend | rise;
`endif
         cand = m_pend & m_en;
         if (m_phase == 0 && cand != 0) begin
            for (int i = 0; i < N; i++) begin
               if (cand[i]) begin m_id = i; break; end
            end
            m_int = 1; m_phase = 1;
         end else if (m_phase == 1 && interrupt_grant) begin
`ifndef CPU_IRQ_LEVEL_EN
            npend[m_id] = rise[m_id];
`endif
            m_int = 0; m_act = 1; m_phase = 2;
         end else if (m_phase == 2 && eoi) begin
            m_act = 0; m_phase = 0;
         end
         m_pend = npend;
         m_prev = irq_src;
         if (irq_en_we) m_en = irq_en_wdata;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("mon_interrupt", 32'(interrupt), 32'(m_int));
         chk("mon_irq_id", 32'(irq_id), 32'(m_id));
         chk("mon_irq_active", 32'(irq_active), 32'(m_act));
         chk("mon_irq_pending", 32'(irq_pending), 32'(m_pend));
         chk("mon_irq_en", 32'(irq_en), 32'(m_en));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_grant();
      interrupt_grant = 1'b1; cyc(); interrupt_grant = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1; cyc(); eoi = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq_src = '0; irq_en_we = 1'b0; irq_en_wdata = '0;
      eoi = 1'b0; interrupt_grant = 1'b0;

      // 1: reset 100 ns, single edge on source 3, request held without grant
      cyc(10);
      chk("rst_interrupt", 32'(interrupt), 32'd0);
      chk("rst_irq_id", 32'(irq_id), 32'd0);
      chk("rst_active", 32'(irq_active), 32'd0);
      chk("rst_pending", 32'(irq_pending), 32'd0);
      chk("rst_en", 32'(irq_en), 32'd0);
      reset = 1'b0;
      irq_en_we = 1'b1; irq_en_wdata = 8'hFF; cyc(); irq_en_we = 1'b0;
      chk("t1_en", 32'(irq_en), 32'hFF);
      irq_src = 8'h08; cyc();
      chk("t1_pending", 32'(irq_pending), 32'h08);
      chk("t1_int_not_yet", 32'(interrupt), 32'd0);
      cyc();
      chk("t1_interrupt", 32'(interrupt), 32'd1);
      chk("t1_irq_id", 32'(irq_id), 32'd3);
      cyc(20);
      chk("t1_int_held", 32'(interrupt), 32'd1);

      // 2: grant then eoi
      pulse_grant();
      chk("t2_int_drop", 32'(interrupt), 32'd0);
      chk("t2_active", 32'(irq_active), 32'd1);
      chk("t2_pending", 32'(irq_pending), 32'h00);
      pulse_eoi();
      chk("t2_active_off", 32'(irq_active), 32'd0);
      irq_src = '0; cyc();

      // 3: simultaneous edges on 5 and 2
      irq_src = 8'h24; cyc();
      chk("t3_pending", 32'(irq_pending), 32'h24);
      cyc();
      chk("t3_first_id", 32'(irq_id), 32'd2);
      pulse_grant();
      chk("t3_pending_after", 32'(irq_pending), 32'h20);
      pulse_eoi();
      chk("t3_idle_no_int", 32'(interrupt), 32'd0);
      cyc();
      chk("t3_second_int", 32'(interrupt), 32'd1);
      chk("t3_second_id", 32'(irq_id), 32'd5);
      pulse_grant(); pulse_eoi();
      irq_src = '0; cyc();

      // 4: masked source, enabled later
      irq_en_we = 1'b1; irq_en_wdata = 8'h00; cyc(); irq_en_we = 1'b0;
      irq_src = 8'h02; cyc();
      chk("t4_pending", 32'(irq_pending), 32'h02);
      cyc();
      chk("t4_masked", 32'(interrupt), 32'd0);
      irq_en_we = 1'b1; irq_en_wdata = 8'h02; cyc(); irq_en_we = 1'b0;
      chk("t4_one_after_write", 32'(interrupt), 32'd0);
      cyc();
      chk("t4_interrupt", 32'(interrupt), 32'd1);
      chk("t4_irq_id", 32'(irq_id), 32'd1);
      pulse_grant(); pulse_eoi();
      irq_src = '0;
      irq_en_we = 1'b1; irq_en_wdata = 8'hFF; cyc(); irq_en_we = 1'b0;

      // 5: stray grant/eoi, and re-edge in the grant cycle
      pulse_grant();
      chk("t5_idle_grant_act", 32'(irq_active), 32'd0);
      chk("t5_idle_grant_int", 32'(interrupt), 32'd0);
      irq_src = 8'h40; cyc(2);
      chk("t5_req_id", 32'(irq_id), 32'd6);
      pulse_eoi();
      chk("t5_eoi_in_req", 32'(interrupt), 32'd1);
      chk("t5_eoi_in_req_act", 32'(irq_active), 32'd0);
      irq_src = 8'h00; cyc();
      irq_src = 8'h40; pulse_grant();
      chk("t5_set_wins", 32'(irq_pending), 32'h40);
      chk("t5_active", 32'(irq_active), 32'd1);
      pulse_eoi();
      cyc();
      chk("t5_rerequest", 32'(interrupt), 32'd1);
      chk("t5_rerequest_id", 32'(irq_id), 32'd6);
      pulse_grant();
      chk("t5_cleared", 32'(irq_pending), 32'h00);

      // 6: reset while in service with pending source 4
      irq_src = 8'h50; cyc();
      chk("t6_pending", 32'(irq_pending), 32'h10);
      reset = 1'b1; irq_src = '0; cyc(); reset = 1'b0;
      chk("t6_int", 32'(interrupt), 32'd0);
      chk("t6_active", 32'(irq_active), 32'd0);
      chk("t6_pending_rst", 32'(irq_pending), 32'h00);
      chk("t6_en_rst", 32'(irq_en), 32'h00);
      cyc(5);
      chk("t6_quiet", 32'(interrupt), 32'd0);
      irq_en_we = 1'b1; irq_en_wdata = 8'hFF; cyc(); irq_en_we = 1'b0;
      irq_src = 8'h01; cyc(2);
      chk("t6_new_edge", 32'(interrupt), 32'd1);
      chk("t6_new_id", 32'(irq_id), 32'd0);
      pulse_grant(); pulse_eoi(); cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_cpu_irq_ctrl
`default_nettype wire
